// File: rtl/poly_dds.sv
// poly_dds -- time-multiplexed polyphonic phase generator (DDS core).
//
// One phase accumulator per voice is kept in a single VOICES-deep memory
// holding {acc, inc}. A self-sequenced FSM visits each voice in turn:
// RD (read), ACC (accumulate and write back), UPD (emit phase and apply
// any pending tuning update). A full frame therefore takes 3*VOICES cycles.
// After reset an INIT sweep clears every memory entry before the first visit.
//
// Ports:
//   i_clk, i_reset_n      clock (rising edge), asynchronous active-low reset
//   i_upd_valid/o_upd_ready
//                         valid/ready handshake for a tuning update
//   i_upd_voice           target voice; indices >= VOICES are dropped
//   i_upd_inc             new phase increment for the target voice
//   i_upd_sync            also clear the target voice's accumulator
//   o_upd_drop            one-cycle pulse after an out-of-range update
//   o_valid               one-cycle pulse qualifying o_phase/o_voice/o_frame
//   o_phase               top OUT_W bits of the voice accumulator
//   o_voice               voice index belonging to o_phase
//   o_frame               high with o_valid for voice 0
//
// Optional feature (macro POLY_DDS_PM_EN): adds input i_pm_offset [OUT_W],
// sampled in ACC and added modulo 2^OUT_W to the emitted phase only; the
// stored accumulator is not affected.
module poly_dds #(
  parameter int VOICES = 16,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 10,
  localparam int VIDX_W = ($clog2(VOICES) > 1) ? $clog2(VOICES) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_upd_valid,
  output logic              o_upd_ready,
  input  logic [7:0]        i_upd_voice,
  input  logic [ACC_W-1:0]  i_upd_inc,
  input  logic              i_upd_sync,
  output logic              o_upd_drop,
`ifdef POLY_DDS_PM_EN
  input  logic [OUT_W-1:0]  i_pm_offset,
`endif
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_phase,
  output logic [VIDX_W-1:0] o_voice,
  output logic              o_frame
);

  localparam logic [VIDX_W-1:0] LAST_VOICE = VIDX_W'(VOICES - 1);
  localparam logic [8:0]        VOICES_9   = 9'(VOICES);

  typedef enum logic [1:0] {S_INIT, S_RD, S_ACC, S_UPD} state_t;

  // Emitted phase: accumulator MSBs plus optional offset, wrapping mod 2^OUT_W.
  function automatic logic [OUT_W-1:0] phase_of(input logic [ACC_W-1:0] acc,
                                                input logic [OUT_W-1:0] offset);
    return acc[ACC_W-1 -: OUT_W] + offset;
  endfunction

  logic [OUT_W-1:0] pm_offset;
`ifdef POLY_DDS_PM_EN
  assign pm_offset = i_pm_offset;
`else
  assign pm_offset = '0;
`endif

  // Control and output flops
  state_t            state_q, state_d;
  logic [VIDX_W-1:0] init_addr_q, init_addr_d;
  logic [VIDX_W-1:0] voice_q, voice_d;
  logic              pending_q, pending_d;
  logic              valid_q, valid_d;
  logic [OUT_W-1:0]  phase_q, phase_d;
  logic [VIDX_W-1:0] out_voice_q, out_voice_d;
  logic              frame_q, frame_d;
  logic              drop_q, drop_d;

  // Update buffer payload (qualified by pending_q, so no reset needed)
  logic [VIDX_W-1:0] pend_voice_q, pend_voice_d;
  logic [ACC_W-1:0]  pend_inc_q, pend_inc_d;
  logic              pend_sync_q, pend_sync_d;

  // Memory: each word is {acc, inc}; one write port with per-field enables.
  logic [2*ACC_W-1:0] mem [VOICES];
  logic [2*ACC_W-1:0] rd_q;
  logic               rd_en;
  logic               mem_we_acc, mem_we_inc;
  logic [VIDX_W-1:0]  mem_addr;
  logic [ACC_W-1:0]   mem_wacc, mem_winc;

  logic [ACC_W-1:0]   acc_new;
  logic               upd_fire;

  assign o_upd_ready = !pending_q && (state_q != S_INIT);
  assign upd_fire    = i_upd_valid && o_upd_ready;
  assign acc_new     = rd_q[2*ACC_W-1:ACC_W] + rd_q[ACC_W-1:0];
  assign rd_en       = (state_q == S_RD);

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    voice_d      = voice_q;
    pending_d    = pending_q;
    valid_d      = 1'b0;
    phase_d      = phase_q;
    out_voice_d  = out_voice_q;
    frame_d      = 1'b0;
    drop_d       = 1'b0;
    pend_voice_d = pend_voice_q;
    pend_inc_d   = pend_inc_q;
    pend_sync_d  = pend_sync_q;
    mem_we_acc   = 1'b0;
    mem_we_inc   = 1'b0;
    mem_addr     = voice_q;
    mem_wacc     = '0;
    mem_winc     = '0;

    case (state_q)
      // Stage INIT: clear one memory word per cycle.
      S_INIT: begin
        mem_addr   = init_addr_q;
        mem_we_acc = 1'b1;
        mem_we_inc = 1'b1;
        if (init_addr_q == LAST_VOICE) begin
          init_addr_d = '0;
          voice_d     = '0;
          state_d     = S_RD;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      // Stage RD: memory read of the current voice is registered into rd_q.
      S_RD: state_d = S_ACC;
      // Stage ACC: write back the new accumulator, register the outputs
      // so they are visible during UPD.
      S_ACC: begin
        mem_we_acc  = 1'b1;
        mem_wacc    = acc_new;
        valid_d     = 1'b1;
        phase_d     = phase_of(acc_new, pm_offset);
        out_voice_d = voice_q;
        frame_d     = (voice_q == '0);
        state_d     = S_UPD;
      end
      // Stage UPD: apply the buffered update. It lands after the ACC
      // write-back, so an update to the voice just visited wins.
      S_UPD: begin
        if (pending_q) begin
          mem_addr   = pend_voice_q;
          mem_we_inc = 1'b1;
          mem_winc   = pend_inc_q;
          mem_we_acc = pend_sync_q;
          pending_d  = 1'b0;
        end
        voice_d = (voice_q == LAST_VOICE) ? '0 : voice_q + 1'b1;
        state_d = S_RD;
      end
      default: state_d = S_INIT;
    endcase

    // Capture; ready already excludes the cycle in which pending clears.
    if (upd_fire) begin
      if ({1'b0, i_upd_voice} < VOICES_9) begin
        pending_d    = 1'b1;
        pend_voice_d = i_upd_voice[VIDX_W-1:0];
        pend_inc_d   = i_upd_inc;
        pend_sync_d  = i_upd_sync;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_INIT;
      init_addr_q <= '0;
      voice_q     <= '0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      phase_q     <= '0;
      out_voice_q <= '0;
      frame_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      voice_q     <= voice_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      phase_q     <= phase_d;
      out_voice_q <= out_voice_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge i_clk) begin
    pend_voice_q <= pend_voice_d;
    pend_inc_q   <= pend_inc_d;
    pend_sync_q  <= pend_sync_d;
  end

  always_ff @(posedge i_clk) begin
    if (mem_we_acc) mem[mem_addr][2*ACC_W-1:ACC_W] <= mem_wacc;
    if (mem_we_inc) mem[mem_addr][ACC_W-1:0]       <= mem_winc;
    if (rd_en)      rd_q <= mem[voice_q];
  end

  assign o_valid    = valid_q;
  assign o_phase    = phase_q;
  assign o_voice    = out_voice_q;
  assign o_frame    = frame_q;
  assign o_upd_drop = drop_q;

endmodule

// File: doc/poly_dds.md
POLY_DDS -- requirements
Module: poly_dds

Interface
REQ-001 SHALL have parameter VOICES, default 16, number of time-multiplexed voices (legal 2..256).
REQ-002 SHALL have parameter ACC_W, default 32, phase accumulator and tuning word width (legal OUT_W+1..48).
REQ-003 SHALL have parameter OUT_W, default 10, output phase width (legal 4..16).
REQ-004 SHALL derive localparam VIDX_W = max(1, clog2(VOICES)).
REQ-005 i_clk  input  1  sole clock, rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_upd_valid  input  1  tuning update offered.
REQ-008 o_upd_ready  output  1  update buffer empty, may accept.
REQ-009 i_upd_voice  input  8  target voice index.
REQ-010 i_upd_inc  input  ACC_W  new phase increment.
REQ-011 i_upd_sync  input  1  also zero the target voice's accumulator.
REQ-012 o_upd_drop  output  1  one-cycle pulse, accepted update discarded as out of range.
REQ-013 o_valid  output  1  one-cycle pulse, o_phase/o_voice valid.
REQ-014 o_phase  output  OUT_W  voice phase, top OUT_W bits of accumulator.
REQ-015 o_voice  output  VIDX_W  voice index of o_phase.
REQ-016 o_frame  output  1  asserted with o_valid when o_voice==0.

Function
REQ-017 SHALL store per voice acc[ACC_W] and inc[ACC_W] in one VOICES-deep memory, synchronous read, one write port.
REQ-018 FSM states: INIT, RD, ACC, UPD; self-sequenced, no external pipeline strobe.
REQ-019 INIT: write acc=0, inc=0 to addresses 0..VOICES-1, one per cycle, then go to RD with voice counter 0.
REQ-020 RD: present current voice address; next state ACC.
REQ-021 ACC: acc_new = (acc + inc) mod 2^ACC_W, write acc_new back; next state UPD.
REQ-022 UPD: drive o_valid=1, o_phase=acc_new[ACC_W-1 -: OUT_W], o_voice=current voice, o_frame=(voice==0); apply pending update if any; increment voice counter, wrap VOICES-1 -> 0; next state RD.
REQ-023 Frame period SHALL be exactly 3*VOICES cycles; o_valid SHALL never assert in INIT.
REQ-024 Handshake: transfer when i_upd_valid && o_upd_ready; capture voice, inc, sync into a one-entry buffer, set pending.
REQ-025 o_upd_ready SHALL equal !pending && state!=INIT; no accept in the cycle pending clears.
REQ-026 Pending update applied only in UPD: write inc; if sync, also write acc=0; clear pending.
REQ-027 Update to the voice just accumulated SHALL land after that write-back (UPD write wins); next visit uses new inc.
REQ-028 i_upd_voice >= VOICES: accepted, discarded at capture, pending stays clear, o_upd_drop pulses cycle after transfer.
REQ-029 Accumulator wrap is silent modulo 2^ACC_W; no saturation.

Reset
REQ-030 i_reset_n low SHALL asynchronously force state=INIT, init address=0, voice=0, pending=0, o_valid=0, o_frame=0, o_upd_drop=0, o_phase=0, o_voice=0, o_upd_ready=0.
REQ-031 Reset mid-frame or mid-update SHALL discard pending update and rerun full INIT sweep after release.
REQ-032 Memory contents need no reset; INIT sweep defines them.

Configuration
REQ-033 Macro POLY_DDS_PM_EN defined: port i_pm_offset input OUT_W exists, sampled in ACC; o_phase = (acc_new top bits + i_pm_offset) mod 2^OUT_W; stored acc unaffected.
REQ-034 POLY_DDS_PM_EN undefined: i_pm_offset absent; o_phase per REQ-022 only.

Verification
REQ-035 Defaults, release reset -> o_upd_ready low 16 cycles, then high; first o_valid: o_voice=0, o_phase=0, o_frame=1.
REQ-036 Update voice 3 inc 0x0040_0000 -> each later frame voice 3 o_phase increments by 1 (0,1,2,...), other voices stay 0.
REQ-037 Voice 5 inc 0x8000_0000 -> o_phase alternates 512, 0 each frame (wrap).
REQ-038 Update voice 3 inc 0x0080_0000 sync=1 offered during voice 3 ACC -> next frame voice 3 o_phase=2, following frame 4; second offer before UPD sees o_upd_ready=0.
REQ-039 VOICES=16, update voice 20 -> o_upd_drop one pulse, all outputs unchanged over two frames.
REQ-040 With POLY_DDS_PM_EN, i_pm_offset=1023, voice phase 1 -> o_phase=0; without macro, same stimulus minus port -> o_phase=1.
